// File: rtl/dac_control.sv
// dac_control: serial DAC write controller.
// Takes a 16-bit code and a 2-bit channel over valid/ready, shifts the 24-bit
// write frame {0001, 00, chan, code} MSB first on csn/sck/sdi, then pulses
// ldacn to update the DAC output.
// Optional feature macro: DAC_CLAMP_EN (clamp code to dac_max_code at transfer
// and report clamp events in dac_status[2:1]).
module dac_control #(
  parameter int HALF_PER = 2,
  parameter int LDAC_W   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dac_wr_valid,
  output logic        dac_wr_ready,
  input  logic [1:0]  dac_wr_chan,
  input  logic [15:0] dac_wr_code,
  input  logic [15:0] dac_max_code,
  input  logic        dac_status_clear,
  output logic        dac_done,
  output logic [7:0]  dac_status,
  output logic        dac_csn,
  output logic        dac_sck,
  output logic        dac_sdi,
  output logic        dac_ldacn
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_LDAC, S_GAP
  } state_t;

  localparam logic [15:0] HP_LAST = 16'(HALF_PER - 1);
  localparam logic [15:0] LD_LAST = 16'(LDAC_W - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  // Shift register; bit 23 drives sdi directly, so sdi is a clean register bit
  // and is zero whenever the register has been cleared outside a frame.
  logic [23:0] shreg_reg, shreg_next;
  logic        csn_reg, csn_next;
  logic        sck_reg, sck_next;
  logic        ldacn_reg, ldacn_next;
  logic        done_reg, done_next;
  logic        ready_reg, ready_next;
  logic        clamp_seen_reg, clamp_seen_next;
  logic        clamp_last_reg, clamp_last_next;

  logic        transfer;
  logic        clamp_hit;
  logic [15:0] code_eff;
  logic        phase_end;
  logic        ldac_end;

  assign transfer  = (state_reg == S_IDLE) && ready_reg && dac_wr_valid;
  assign phase_end = (cnt_reg == HP_LAST);
  assign ldac_end  = (cnt_reg == LD_LAST);

`ifdef DAC_CLAMP_EN
  assign clamp_hit = (dac_wr_code > dac_max_code);
  assign code_eff  = clamp_hit ? dac_max_code : dac_wr_code;

  // Sticky flag: a clamp event in the same cycle as clear keeps the flag set.
  always_comb begin
    clamp_seen_next = clamp_seen_reg;
    clamp_last_next = clamp_last_reg;
    if (transfer) begin
      clamp_last_next = clamp_hit;
    end
    if (transfer && clamp_hit) begin
      clamp_seen_next = 1'b1;
    end else if (dac_status_clear) begin
      clamp_seen_next = 1'b0;
    end
  end
`else
  logic unused_clamp_inputs;
  assign unused_clamp_inputs = ^{dac_max_code, dac_status_clear};
  assign clamp_hit = 1'b0;
  assign code_eff  = dac_wr_code;

  // Clamp reporting is absent in this build; flags stay cleared.
  always_comb begin
    clamp_seen_next = 1'b0;
    clamp_last_next = 1'b0;
  end
`endif

  // Next-state, phase timing, shifting and registered pin values.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 16'd1;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = 16'd0;
        if (transfer) begin
          state_next   = S_SETUP;
          shreg_next   = {4'b0001, 2'b00, dac_wr_chan, code_eff};
          bit_cnt_next = 5'd23;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_next = S_HIGH;
          cnt_next   = 16'd0;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_next = 16'd0;
          if (bit_cnt_reg == 5'd0) begin
            state_next = S_HOLD;
          end else begin
            state_next   = S_LOW;
            bit_cnt_next = bit_cnt_reg - 5'd1;
            shreg_next   = {shreg_reg[22:0], 1'b0};
          end
        end
      end
      S_LOW: begin
        if (phase_end) begin
          state_next = S_HIGH;
          cnt_next   = 16'd0;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_next = S_LDAC;
          cnt_next   = 16'd0;
          shreg_next = 24'd0;
        end
      end
      S_LDAC: begin
        if (ldac_end) begin
          state_next = S_GAP;
          cnt_next   = 16'd0;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          state_next = S_IDLE;
          cnt_next   = 16'd0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 16'd0;
        shreg_next = 24'd0;
      end
    endcase

    csn_next   = !((state_next == S_SETUP) || (state_next == S_HIGH) ||
                   (state_next == S_LOW)   || (state_next == S_HOLD));
    sck_next   = (state_next == S_HIGH);
    ldacn_next = (state_next != S_LDAC);
    done_next  = (state_reg == S_GAP) && phase_end;
    // Ready comes back the cycle after the done pulse.
    ready_next = (state_next == S_IDLE) && !done_next;
  end

  // State and registered outputs; asynchronous reset returns pins to idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 16'd0;
      bit_cnt_reg    <= 5'd0;
      shreg_reg      <= 24'd0;
      csn_reg        <= 1'b1;
      sck_reg        <= 1'b0;
      ldacn_reg      <= 1'b1;
      done_reg       <= 1'b0;
      ready_reg      <= 1'b0;
      clamp_seen_reg <= 1'b0;
      clamp_last_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      csn_reg        <= csn_next;
      sck_reg        <= sck_next;
      ldacn_reg      <= ldacn_next;
      done_reg       <= done_next;
      ready_reg      <= ready_next;
      clamp_seen_reg <= clamp_seen_next;
      clamp_last_reg <= clamp_last_next;
    end
  end

  assign dac_wr_ready = ready_reg;
  assign dac_done     = done_reg;
  assign dac_csn      = csn_reg;
  assign dac_sck      = sck_reg;
  assign dac_sdi      = shreg_reg[23];
  assign dac_ldacn    = ldacn_reg;
  assign dac_status   = {5'b0, clamp_seen_reg, clamp_last_reg, (state_reg != S_IDLE)};

endmodule

// File: tb/tb_dac_control.sv
// tb_dac_control: randomized self-checking bench for dac_control.
// A pin-level monitor rebuilds each frame from csn/sck/sdi and measures its
// timing; expected frames and status come from a small write-level model.
module tb_dac_control;
  localparam int HP = 2;
  localparam int LW = 2;
`ifdef DAC_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  chan = 2'd0;
  logic [15:0] code = 16'd0;
  logic [15:0] maxc = 16'hFFFF;
  logic        ready, done, csn, sck, sdi, ldacn;
  logic [7:0]  status;

  always #5 clk = ~clk;

  dac_control #(.HALF_PER(HP), .LDAC_W(LW)) dut (
    .clk(clk), .rstn(rstn), .dac_wr_valid(valid), .dac_wr_ready(ready),
    .dac_wr_chan(chan), .dac_wr_code(code), .dac_max_code(maxc),
    .dac_status_clear(clear), .dac_done(done), .dac_status(status),
    .dac_csn(csn), .dac_sck(sck), .dac_sdi(sdi), .dac_ldacn(ldacn)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0] frame;
    int low; int rises; int ldac; int delay; int gap;
  } rec_t;

  logic [23:0] exp_q[$];
  rec_t        obs_q[$];
  bit          m_seen = 1'b0;
  bit          m_last = 1'b0;

  function automatic logic [23:0] model_frame(input logic [1:0] c, input logic [15:0] d,
                                              input logic [15:0] m);
    logic [15:0] e;
    e = (CLAMP && (d > m)) ? m : d;
    return {4'b0001, 2'b00, c, e};
  endfunction

  // ---------------- pin monitor (samples on falling clk) ----------------
  int cyc = 0;
  logic prev_csn = 1'b1, prev_sck = 1'b0;
  logic [23:0] acc = 24'd0;
  int low_c = 0, rise_c = 0, ldac_c = 0, high_c = 0, last_gap = -1, rise_cyc = 0;
  bit pend = 1'b0;
  rec_t pr;
  int done_cnt = 0, transfers = 0, last_done_cyc = 0, last_xfer_cyc = 0;
  int sdi_viol = 0, sck_viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      prev_csn = 1'b1; prev_sck = 1'b0; low_c = 0; rise_c = 0; ldac_c = 0;
      pend = 1'b0; high_c = 0; last_gap = -1;
    end else begin
      if (valid && ready) begin transfers++; last_xfer_cyc = cyc; end
      if (csn && sdi) sdi_viol++;
      if (csn && sck) sck_viol++;
      if (!csn) begin
        if (prev_csn) begin acc = 24'd0; low_c = 0; rise_c = 0; last_gap = high_c; end
        low_c++;
        if (sck && !prev_sck) begin acc = {acc[22:0], sdi}; rise_c++; end
      end else begin
        if (!prev_csn) begin
          pr.frame = acc; pr.low = low_c; pr.rises = rise_c; pr.gap = last_gap;
          ldac_c = 0; rise_cyc = cyc; pend = 1'b1; high_c = 0;
        end
        high_c++;
      end
      if (!ldacn) ldac_c++;
      if (done) begin
        done_cnt++; last_done_cyc = cyc;
        if (pend) begin
          pr.ldac = ldac_c; pr.delay = cyc - rise_cyc; obs_q.push_back(pr); pend = 1'b0;
        end
      end
      prev_csn = csn; prev_sck = sck;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [1:0] c, input logic [15:0] d, input logic [15:0] m);
    int n = 0;
    bit hit;
    @(posedge clk); #1;
    chan = c; code = d; maxc = m; valid = 1'b1;
    while (n < 400) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL write_timeout ready=%b want 1", ready); end
    hit = CLAMP && (d > m);
    exp_q.push_back(model_frame(c, d, m));
    m_last = hit;
    if (hit) m_seen = 1'b1;
    else if (clear) m_seen = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
    #1;
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL %s done_timeout waited=%0d want <2000", tag, n); end
  endtask

  task automatic pop_obs(output rec_t r);
    if (obs_q.size() > 0) r = obs_q.pop_front();
    else begin r.frame = 24'hxxxxxx; r.low = -1; r.rises = -1; r.ldac = -1; r.delay = -1; r.gap = -1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (csn !== 1'b1) begin errors++; $display("FAIL reset_csn got %b want 1", csn); end
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck); end
    checks++; if (sdi !== 1'b0) begin errors++; $display("FAIL reset_sdi got %b want 0", sdi); end
    checks++; if (ldacn !== 1'b1) begin errors++; $display("FAIL reset_ldacn got %b want 1", ldacn); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", status); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", ready); end
    $display("reset: released, ready=%b status=%h", ready, status);
  endtask

  task automatic test_single();
    rec_t r; logic [23:0] e;
    do_write(2'd1, 16'hA5C3, 16'hFFFF);
    wait_done("single");
    e = exp_q.pop_front();
    pop_obs(r);
    $display("single: frame=%h low=%0d rises=%0d ldac=%0d delay=%0d", r.frame, r.low, r.rises, r.ldac, r.delay);
    checks++; if (r.frame !== e) begin errors++; $display("FAIL single_frame got %h want %h", r.frame, e); end
    checks++; if (r.low != 49*HP) begin errors++; $display("FAIL single_csn_low got %0d want %0d", r.low, 49*HP); end
    checks++; if (r.rises != 24) begin errors++; $display("FAIL single_rises got %0d want 24", r.rises); end
    checks++; if (r.ldac != LW) begin errors++; $display("FAIL single_ldac got %0d want %0d", r.ldac, LW); end
    checks++; if (r.delay != HP+LW) begin errors++; $display("FAIL single_done_delay got %0d want %0d", r.delay, HP+LW); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_after got %b want 1", ready); end
  endtask

  task automatic test_back_to_back();
    rec_t r1, r2; logic [23:0] e1, e2; int n; logic [1:0] c;
    c = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    chan = c; code = 16'h0001; maxc = 16'hFFFF; valid = 1'b1;
    n = 0; while (n < 400) begin @(negedge clk); if (ready === 1'b1) break; n++; end
    exp_q.push_back(model_frame(c, 16'h0001, 16'hFFFF)); m_last = 1'b0;
    @(posedge clk); #1;
    code = 16'hFFFE;
    wait_done("b2b_first");
    n = 0; while (n < 400) begin @(negedge clk); if (ready === 1'b1) break; n++; end
    #1;
    checks++; if (last_xfer_cyc != last_done_cyc + 1)
      begin errors++; $display("FAIL b2b_xfer_cycle got %0d want %0d", last_xfer_cyc, last_done_cyc + 1); end
    exp_q.push_back(model_frame(c, 16'hFFFE, 16'hFFFF));
    @(posedge clk); #1;
    valid = 1'b0;
    wait_done("b2b_second");
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    pop_obs(r1); pop_obs(r2);
    $display("b2b: frames=%h,%h gap=%0d rises=%0d,%0d", r1.frame, r2.frame, r2.gap, r1.rises, r2.rises);
    checks++; if (r1.frame !== e1) begin errors++; $display("FAIL b2b_frame1 got %h want %h", r1.frame, e1); end
    checks++; if (r2.frame !== e2) begin errors++; $display("FAIL b2b_frame2 got %h want %h", r2.frame, e2); end
    checks++; if (r2.gap < LW+HP+1) begin errors++; $display("FAIL b2b_gap got %0d want >=%0d", r2.gap, LW+HP+1); end
    checks++; if (r1.rises != 24 || r2.rises != 24)
      begin errors++; $display("FAIL b2b_rises got %0d,%0d want 24,24", r1.rises, r2.rises); end
    checks++; if (sck_viol != 0) begin errors++; $display("FAIL b2b_sck_idle got %0d want 0", sck_viol); end
  endtask

  task automatic test_clamp();
    rec_t r; logic [23:0] e; logic [7:0] es;
    do_write(2'd2, 16'hFFFF, 16'h8000);
    @(negedge clk);
    es = {5'b0, m_seen, m_last, 1'b1};
    checks++; if (status !== es) begin errors++; $display("FAIL clamp_status1 got %h want %h", status, es); end
    wait_done("clamp1");
    e = exp_q.pop_front(); pop_obs(r);
    $display("clamp: code=ffff max=8000 frame=%h status=%h", r.frame, es);
    checks++; if (r.frame !== e) begin errors++; $display("FAIL clamp_frame1 got %h want %h", r.frame, e); end
    do_write(2'd2, 16'h1234, 16'h8000);
    @(negedge clk);
    es = {5'b0, m_seen, m_last, 1'b1};
    checks++; if (status !== es) begin errors++; $display("FAIL clamp_status2 got %h want %h", status, es); end
    wait_done("clamp2");
    e = exp_q.pop_front(); pop_obs(r);
    $display("clamp: code=1234 max=8000 frame=%h status=%h", r.frame, es);
    checks++; if (r.frame !== e) begin errors++; $display("FAIL clamp_frame2 got %h want %h", r.frame, e); end
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0; m_seen = 1'b0;
    @(negedge clk);
    es = {5'b0, m_seen, m_last, 1'b0};
    checks++; if (status !== es) begin errors++; $display("FAIL clamp_clear got %h want %h", status, es); end
    // Clear held across a clamped transfer: the new event must win.
    clear = 1'b1;
    do_write(2'd0, 16'hFFFF, 16'h8000);
    clear = 1'b0;
    @(negedge clk);
    es = {5'b0, m_seen, m_last, 1'b1};
    $display("clamp: clear with clamped transfer status=%h", status);
    checks++; if (status !== es) begin errors++; $display("FAIL clamp_set_wins got %h want %h", status, es); end
    wait_done("clamp3");
    e = exp_q.pop_front(); pop_obs(r);
    checks++; if (r.frame !== e) begin errors++; $display("FAIL clamp_frame3 got %h want %h", r.frame, e); end
  endtask

  task automatic test_busy();
    rec_t r; logic [23:0] e; int t0, rdy_hi;
    do_write(2'd3, 16'h5A5A, 16'hFFFF);
    t0 = transfers;
    rdy_hi = 0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    code = 16'($urandom); chan = 2'd0; maxc = 16'h0000; valid = 1'b1;
    repeat (40) begin @(negedge clk); if (ready !== 1'b0) rdy_hi++; end
    @(posedge clk); #1; valid = 1'b0;
    #1;
    checks++; if (rdy_hi != 0) begin errors++; $display("FAIL busy_ready got %0d want 0", rdy_hi); end
    checks++; if (transfers != t0) begin errors++; $display("FAIL busy_transfers got %0d want %0d", transfers, t0); end
    wait_done("busy");
    e = exp_q.pop_front(); pop_obs(r);
    $display("busy: frame=%h ready_high=%0d", r.frame, rdy_hi);
    checks++; if (r.frame !== e) begin errors++; $display("FAIL busy_frame got %h want %h", r.frame, e); end
  endtask

  task automatic test_reset_mid();
    rec_t r; logic [23:0] e; int n, d0;
    do_write(2'd1, 16'($urandom), 16'hFFFF);
    n = 0; while (n < 500) begin @(negedge clk); #1; if (rise_c >= 10) break; n++; end
    d0 = done_cnt;
    #1 rstn = 1'b0;
    #1;
    checks++; if (csn !== 1'b1 || sck !== 1'b0 || sdi !== 1'b0 || ldacn !== 1'b1)
      begin errors++; $display("FAIL midreset_pins got csn=%b sck=%b sdi=%b ldacn=%b want 1 0 0 1", csn, sck, sdi, ldacn); end
    checks++; if (ready !== 1'b0 || status !== 8'h00)
      begin errors++; $display("FAIL midreset_ctrl got ready=%b status=%h want 0 00", ready, status); end
    exp_q.delete(); m_seen = 1'b0; m_last = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    $display("midreset: rises_before=%0d done_after=%0d", n, done_cnt - d0);
    checks++; if (done_cnt != d0 || obs_q.size() != 0)
      begin errors++; $display("FAIL midreset_no_done got %0d frames=%0d want 0 0", done_cnt - d0, obs_q.size()); end
    do_write(2'd2, 16'h0F0F, 16'hFFFF);
    wait_done("after_reset");
    e = exp_q.pop_front(); pop_obs(r);
    checks++; if (r.frame !== e) begin errors++; $display("FAIL midreset_frame got %h want %h", r.frame, e); end
  endtask

  task automatic test_random();
    rec_t r; logic [23:0] e; logic [7:0] es; logic [1:0] c; logic [15:0] d, m;
    for (int i = 0; i < 8; i++) begin
      c = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      m = (i % 3 == 0) ? 16'hFFFF : 16'($urandom);
      do_write(c, d, m);
      @(negedge clk);
      es = {5'b0, m_seen, m_last, 1'b1};
      checks++; if (status !== es) begin errors++; $display("FAIL rand%0d_status got %h want %h", i, status, es); end
      wait_done("random");
      e = exp_q.pop_front(); pop_obs(r);
      $display("random %0d: chan=%0d code=%h max=%h frame=%h", i, c, d, m, r.frame);
      checks++; if (r.frame !== e) begin errors++; $display("FAIL rand%0d_frame got %h want %h", i, r.frame, e); end
      checks++; if (r.low != 49*HP || r.rises != 24)
        begin errors++; $display("FAIL rand%0d_timing got low=%0d rises=%0d want %0d 24", i, r.low, r.rises, 49*HP); end
    end
    checks++; if (sdi_viol != 0) begin errors++; $display("FAIL sdi_idle got %0d want 0", sdi_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clamp();
    test_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim_time=%0t want finish before 1ms", $time);
    $fatal(1);
  end
endmodule

// File: doc/dac_control.md
# dac_control

Serial DAC write controller: the transmit-side counterpart of the monitor ADC capture path. It accepts a 16-bit code and a channel number over a valid/ready handshake and shifts a 24-bit write frame to an external SPI DAC on CSn/SCK/SDI. After each frame it pulses LDACn to update the output. It sits beside the ADC controller and is driven by the same register/command logic that sets DDS and CW drive levels.

## Interface
- `HALF_PER`, default 2: SCK half-period in clk cycles. Minimum 1.
- `LDAC_W`, default 2: LDACn low-pulse width in clk cycles. Minimum 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `dac_wr_valid`  in  1  write request.
- `dac_wr_ready`  out  1  high only in IDLE; a write transfers on a cycle where valid and ready are both high.
- `dac_wr_chan`  in  2  DAC channel; sampled at transfer.
- `dac_wr_code`  in  16  DAC code; sampled at transfer.
- `dac_max_code`  in  16  clamp ceiling; sampled at transfer; used only with `DAC_CLAMP_EN`.
- `dac_status_clear`  in  1  synchronous clear of the sticky clamp flag.
- `dac_done`  out  1  one-cycle pulse when a frame is complete.
- `dac_status`  out  8  {5'b0, clamp_seen, clamp_last, busy}.
- `dac_csn`, `dac_sck`, `dac_sdi`, `dac_ldacn`  out  1 each  DAC pins.

## Operation
- Frame word is 24 bits: {4'b0001, 2'b00, chan[1:0], code[15:0]}, shifted MSB first. Command 0001 means "write input register".
- All fields are latched at transfer. Input changes while busy have no effect.
- States:
  - IDLE: ready=1, csn=1, sck=0. On transfer → SETUP.
  - SETUP: csn=0, sck=0, sdi=bit23, for HALF_PER cycles → HIGH.
  - HIGH: sck=1 for HALF_PER cycles. The DAC samples SDI on the SCK rising edge. After bit 0 → HOLD; otherwise → LOW.
  - LOW: sck=0, sdi=next bit (changes on entry only), for HALF_PER cycles → HIGH.
  - HOLD: sck=0, csn=0, for HALF_PER cycles → LDAC. csn rises on LDAC entry.
  - LDAC: ldacn=0 for LDAC_W cycles → GAP.
  - GAP: csn=1, ldacn=1, for HALF_PER cycles → IDLE, with dac_done=1 on that same transition.
- busy = state≠IDLE.
- SCK and SDI are registered outputs and must be glitch-free.
- sdi=0 whenever csn=1.

## Timing
- Reset values: csn=1, sck=0, sdi=0, ldacn=1, ready=0 while rstn=0 then 1 in IDLE, done=0, status=0.
- Transfer at cycle T. csn falls at T+1.
- csn low for 2·HALF_PER + 24·HALF_PER + 23·HALF_PER cycles. This is 98 cycles at HALF_PER=2.
- Exactly 24 SCK rising edges per frame. Each SDI bit is stable for HALF_PER cycles before and after its rising edge.
- dac_done fires HALF_PER+LDAC_W cycles after csn rises. ready is high in the following cycle.
- Back-to-back writes: csn stays high for at least LDAC_W+HALF_PER+1 cycles between frames.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous) and the frame is abandoned. No done pulse.
- dac_status_clear asserted in the same cycle as a new clamp event: set wins.

## Configuration
- `DAC_CLAMP_EN` defined:
  - At transfer, if code > dac_max_code (unsigned), dac_max_code is latched in place of code.
  - clamp_last (status[1]) is set to 1 for a clamped write and 0 for an unclamped one.
  - clamp_seen (status[2]) sets and stays set until dac_status_clear.
- `DAC_CLAMP_EN` undefined:
  - Code is passed through unmodified; dac_max_code is ignored.
  - status[2:1] are held at 0.

## Test plan
- Reset: hold rstn=0 → csn=1, sck=0, sdi=0, ldacn=1, done=0, status=0. After release, ready=1 on the first clk.
- Single write, chan=1, code=0xA5C3, HALF_PER=2:
  - Sampling sdi on 24 rising SCK edges yields 0x11A5C3.
  - csn is low for 98 cycles, then ldacn is low for 2 cycles, then one dac_done pulse.
- Back-to-back: hold valid high with codes 0x0001 then 0xFFFE. The second transfer occurs on the cycle after done. There is no extra SCK edge and csn stays high for ≥5 cycles between frames.
- Clamp (`DAC_CLAMP_EN`):
  - max=0x8000, code=0xFFFF → frame data 0x8000, status=0x07 during the frame.
  - Then code=0x1234 → data 0x1234, status[2:1]=2'b10.
  - Pulse clear → status[2]=0.
- Reset mid-frame: drop rstn after the 10th SCK rise → csn=1 and sck=0 at once, no done pulse. After release, a new write of 0x0F0F shifts correctly.
- Busy isolation: change dac_wr_code and assert valid during a frame → shifted data is unchanged, ready stays 0, and no second transfer occurs until IDLE.
